student_and_accum: RTL

Parametrised streaming bitwise-reduction unit, the sequential successor to the 16-bit AND array. It accepts a frame of WIDTH-bit words over a valid/ready handshake and folds them bit-by-bit with a selectable operator (AND, OR, XOR, NAND). It presents one registered result word per frame, with a beat count and an overflow flag. It sits between a word producer and any consumer that needs a per-frame mask or parity word.

---
 rtl/student_logic_pkg.sv | 17 +
 rtl/student_and.sv | 8 +
 rtl/student_bitop_n.sv | 33 +++
 rtl/student_or.sv | 8 +
 rtl/student_xor.sv | 8 +
 rtl/student_and_accum.sv | 89 ++++++++
 6 files changed

// File: rtl/student_logic_pkg.sv
// rtl/student_logic_pkg.sv - shared operator codes and FSM state encodings
package student_logic_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/student_and.sv
// rtl/student_and.sv - single-bit AND gate
module student_and (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

// File: rtl/student_bitop_n.sv
// rtl/student_bitop_n.sv - WIDTH-bit combinational AND/OR/XOR unit with op select
module student_bitop_n
   import student_logic_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] and_y;
   logic [WIDTH-1:0] or_y;
   logic [WIDTH-1:0] xor_y;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      student_and u_and (.a(a[i]), .b(b[i]), .y(and_y[i]));
      student_or  u_or  (.a(a[i]), .b(b[i]), .y(or_y[i]));
      student_xor u_xor (.a(a[i]), .b(b[i]), .y(xor_y[i]));
   end

   // NAND frames fold with AND; the inversion happens once at the output
   always_comb begin
      y = and_y;
      case (op)
         OP_OR:   y = or_y;
         OP_XOR:  y = xor_y;
         default: y = and_y;
      endcase
   end

endmodule

// File: rtl/student_or.sv
// rtl/student_or.sv - single-bit OR gate
module student_or (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

// File: rtl/student_xor.sv
// rtl/student_xor.sv - single-bit XOR gate
module student_xor (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// File: rtl/student_and_accum.sv
// rtl/student_and_accum.sv - streaming per-frame bitwise reduction with beat count and overflow
module student_and_accum
   import student_logic_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow
);

   state_e           state, state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] fold;
   op_e              op_r;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             accept;
   logic             first;

   assign in_ready = (state != S_HOLD) || out_ready;
   assign accept   = in_valid && in_ready;
   // A beat accepted in IDLE, or in HOLD while the result drains, opens a new frame
   assign first    = (state == S_IDLE) || (state == S_HOLD);

   student_bitop_n #(.WIDTH(WIDTH)) u_bitop (
      .a  (acc),
      .b  (in_data),
      .op (op_r),
      .y  (fold)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (accept) state_nxt = in_last ? S_HOLD : S_ACCUM;
         S_ACCUM:
            if (accept && in_last) state_nxt = S_HOLD;
         S_HOLD:
            if (out_ready) begin
               if (accept) state_nxt = in_last ? S_HOLD : S_ACCUM;
               else        state_nxt = S_IDLE;
            end
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         acc   <= '0;
         op_r  <= OP_AND;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            if (first) begin
               acc   <= in_data;
               op_r  <= op_e'(in_op);
               count <= CNT_W'(1);
               ovf   <= 1'b0;
            end else begin
               acc <= fold;
               if (count == '1) ovf   <= 1'b1;
               else             count <= count + CNT_W'(1);
            end
         end
      end
   end

   assign out_valid    = (state == S_HOLD);
   assign out_data     = (op_r == OP_NAND) ? ~acc : acc;
   assign out_count    = count;
   assign out_overflow = ovf;

endmodule
